// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encoding, sweep
// direction and helpers that size the prescaler and tick counters.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running divide-by-DIV prescaler producing a registered one-cycle tick.
// The clear input restarts the count so the first tick lands DIV edges later.
module led_tick_prescaler
  import led_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            W    = cnt_width(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] presc;
  logic         wrap;

  assign wrap = (presc == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= wrap;
      presc <= wrap ? '0 : presc + W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED driver: off / on / square-wave blink / triangular-PWM breathe, with a
// registered output. Any change of the selected mode restarts all timebases.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int BLINK_TICKS = 500,
  parameter int PWM_BITS    = 8,
  parameter int RAMP_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic       led_out,
  output logic       tick
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int BW  = cnt_width(BLINK_TICKS);
  localparam int RW  = cnt_width(RAMP_TICKS);

  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [RW-1:0]       RAMP_LAST  = RW'(RAMP_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

  if (DIV < 2) begin : g_bad_div
    $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (BLINK_TICKS < 1 || RAMP_TICKS < 1 || PWM_BITS < 2) begin : g_bad_param
    $error("led_pattern_gen: BLINK_TICKS, RAMP_TICKS >= 1 and PWM_BITS >= 2 required");
  end

  mode_e               mode_q;
  logic                chg;
  logic [BW-1:0]       bcnt,  bcnt_d;
  logic                blink_lvl, blink_lvl_d;
  logic [PWM_BITS-1:0] pcnt,  pcnt_d;
  logic [PWM_BITS-1:0] duty,  duty_d;
  dir_e                dir,   dir_d;
  logic [RW-1:0]       rcnt,  rcnt_d;
  logic                led_d;

  assign chg = (mode != mode_q);

  led_tick_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (chg),
    .tick (tick)
  );

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    bcnt_d      = bcnt;
    blink_lvl_d = blink_lvl;
    pcnt_d      = pcnt;
    duty_d      = duty;
    dir_d       = dir;
    rcnt_d      = rcnt;
    if (chg) begin
      bcnt_d      = '0;
      blink_lvl_d = 1'b1;
      pcnt_d      = '0;
      duty_d      = '0;
      dir_d       = DIR_UP;
      rcnt_d      = '0;
    end else begin
      if (mode_q == MODE_BLINK && tick) begin
        if (bcnt == BLINK_LAST) begin
          bcnt_d      = '0;
          blink_lvl_d = ~blink_lvl;
        end else begin
          bcnt_d = bcnt + 1'b1;
        end
      end
      if (mode_q == MODE_BREATHE) begin
        pcnt_d = pcnt + 1'b1;
        if (tick) begin
          if (rcnt != RAMP_LAST) begin
            rcnt_d = rcnt + 1'b1;
          end else begin
            rcnt_d = '0;
            // Bounce off either end of the duty range instead of wrapping.
            if (dir == DIR_UP) begin
              if (duty == DUTY_MAX) begin
                duty_d = duty - 1'b1;
                dir_d  = DIR_DOWN;
              end else begin
                duty_d = duty + 1'b1;
              end
            end else begin
              if (duty == '0) begin
                duty_d = duty + 1'b1;
                dir_d  = DIR_UP;
              end else begin
                duty_d = duty - 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // The output flop looks at post-edge state, so blink half-periods are exact.
  always_comb begin
    led_d = 1'b0;
    unique case (mode_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = blink_lvl_d;
      MODE_BREATHE: led_d = (pcnt_d < duty_d);
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_OFF;
      led_out   <= 1'b0;
      bcnt      <= '0;
      blink_lvl <= 1'b1;
      pcnt      <= '0;
      duty      <= '0;
      dir       <= DIR_UP;
      rcnt      <= '0;
    end else begin
      mode_q    <= mode_e'(mode);
      led_out   <= led_d;
      bcnt      <= bcnt_d;
      blink_lvl <= blink_lvl_d;
      pcnt      <= pcnt_d;
      duty      <= duty_d;
      dir       <= dir_d;
      rcnt      <= rcnt_d;
    end
  end

endmodule
